// File: rtl/stoch_dot_prod_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// stoch_dot_prod_ctrl_pkg
// Shared definitions for the stochastic dot-product block:
//   - ctrl_state_t   : controller FSM state encoding
//   - result_width() : width needed to hold a ones count of 0..num_cycles
//   - lane_sum_width(): width needed to hold a popcount of 0..vec_len lanes
// No ports (package).
// ---------------------------------------------------------------------------
package stoch_dot_prod_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_RUN   = 2'd2,
        ST_DONE  = 2'd3
    } ctrl_state_t;

    // A window of num_cycles cycles can produce num_cycles ones, so the
    // count needs one bit more than the index range.
    function automatic int result_width(input int num_cycles);
        return $clog2(num_cycles) + 1;
    endfunction

    function automatic int lane_sum_width(input int vec_len);
        return $clog2(vec_len + 1);
    endfunction

endpackage

// File: rtl/stoch_dot_prod.sv
// ---------------------------------------------------------------------------
// stoch_dot_prod
// Stochastic dot product of two bitstream vectors.
// Each lane multiplies by ANDing u[i] & v[i]; the lane products are summed
// into an accumulator that is drained by one unit per output one, so the
// output stream y carries the (unscaled) sum of the products as a unary
// stream: y=1 whenever the accumulator plus this cycle's products is
// non-zero, and that unit is consumed.
// Ports:
//   CLK   in   clock, rising edge
//   nRST  in   synchronous active-low reset of the accumulator
//   u     in   [VEC_LEN] operand bitstream vector A
//   v     in   [VEC_LEN] operand bitstream vector B
//   y     out  dot-product output bitstream (combinational from acc, u, v)
// ---------------------------------------------------------------------------
module stoch_dot_prod
    import stoch_dot_prod_ctrl_pkg::*;
#(
    parameter int VEC_LEN      = 2,
    parameter int COUNTER_SIZE = 8
) (
    input  logic               CLK,
    input  logic               nRST,
    input  logic [VEC_LEN-1:0] u,
    input  logic [VEC_LEN-1:0] v,
    output logic               y
);

    localparam int SUM_W = lane_sum_width(VEC_LEN);
    localparam int TOT_W = COUNTER_SIZE + 1;
    localparam logic [COUNTER_SIZE-1:0] ACC_MAX  = {COUNTER_SIZE{1'b1}};
    localparam logic [TOT_W-1:0]        ACC_MAXW = {1'b0, {COUNTER_SIZE{1'b1}}};

    logic [VEC_LEN-1:0]      prod;
    logic [SUM_W-1:0]        lane_sum;
    logic [TOT_W-1:0]        total;
    logic [TOT_W-1:0]        drained;
    logic [COUNTER_SIZE-1:0] acc;
    logic [COUNTER_SIZE-1:0] acc_next;

    assign prod = u & v;

    always_comb begin
        lane_sum = '0;
        for (int i = 0; i < VEC_LEN; i++) begin
            lane_sum = lane_sum + SUM_W'(prod[i]);
        end
    end

    // The extra total bit catches the case where acc is near full and new
    // products arrive; the accumulator saturates rather than wrapping.
    always_comb begin
        total    = {1'b0, acc} + TOT_W'(lane_sum);
        y        = (total != '0);
        drained  = total - TOT_W'(y);
        acc_next = (drained > ACC_MAXW) ? ACC_MAX : drained[COUNTER_SIZE-1:0];
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            acc <= '0;
        end else begin
            acc <= acc_next;
        end
    end

endmodule

// File: rtl/stoch_dot_prod_ctrl.sv
// ---------------------------------------------------------------------------
// stoch_dot_prod_ctrl
// Runs the stochastic dot product over a fixed window of NUM_CYCLES cycles
// and reports how many cycles of that window produced y=1.
// Sequence: IDLE -> CLEAR (1 cycle, datapath held in reset, counters
// zeroed) -> RUN (NUM_CYCLES cycles) -> DONE (1 cycle, done pulse) -> IDLE.
// abort in CLEAR/RUN returns to IDLE without touching result.
// Ports:
//   CLK     in   clock, rising edge
//   nRST    in   synchronous active-low reset
//   start   in   request a window (accepted only in IDLE, abort wins)
//   abort   in   cancel the window in progress
//   u, v    in   [VEC_LEN] operand bitstream vectors
//   busy    out  high in CLEAR and RUN
//   done    out  one-cycle pulse in DONE
//   y       out  datapath bitstream, forced to 0 outside RUN
//   result  out  [RESULT_WIDTH] ones count of the last completed window
// ---------------------------------------------------------------------------
module stoch_dot_prod_ctrl
    import stoch_dot_prod_ctrl_pkg::*;
#(
    parameter int VEC_LEN      = 2,
    parameter int COUNTER_SIZE = 8,
    parameter int NUM_CYCLES   = 256,
    parameter int RESULT_WIDTH = result_width(NUM_CYCLES)
) (
    input  logic                    CLK,
    input  logic                    nRST,
    input  logic                    start,
    input  logic                    abort,
    input  logic [VEC_LEN-1:0]      u,
    input  logic [VEC_LEN-1:0]      v,
    output logic                    busy,
    output logic                    done,
    output logic                    y,
    output logic [RESULT_WIDTH-1:0] result
);

    localparam logic [RESULT_WIDTH-1:0] LAST_CYC = RESULT_WIDTH'(NUM_CYCLES - 1);

    ctrl_state_t             state;
    logic                    in_run;
    logic                    last_run;
    logic                    dp_rst_n;
    logic                    dp_y;
    logic [VEC_LEN-1:0]      u_run;
    logic [VEC_LEN-1:0]      v_run;
    logic [RESULT_WIDTH-1:0] cyc_cnt;
    logic [RESULT_WIDTH-1:0] ones_cnt;
    logic [RESULT_WIDTH-1:0] ones_total;

    assign in_run   = (state == ST_RUN);
    assign last_run = in_run && (cyc_cnt == LAST_CYC);

    // Lanes only see live data while running; the datapath accumulator is
    // cleared during the CLEAR cycle so no window inherits another's residue.
    assign u_run    = u & {VEC_LEN{in_run}};
    assign v_run    = v & {VEC_LEN{in_run}};
    assign dp_rst_n = nRST & (state != ST_CLEAR);

    assign y = dp_y & in_run;

    // Includes the current cycle's y so the final RUN cycle is counted.
    assign ones_total = ones_cnt + RESULT_WIDTH'(y);

    stoch_dot_prod #(
        .VEC_LEN      (VEC_LEN),
        .COUNTER_SIZE (COUNTER_SIZE)
    ) u_dp (
        .CLK  (CLK),
        .nRST (dp_rst_n),
        .u    (u_run),
        .v    (v_run),
        .y    (dp_y)
    );

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state    <= ST_IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            result   <= '0;
            cyc_cnt  <= '0;
            ones_cnt <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start && !abort) begin
                        state <= ST_CLEAR;
                        busy  <= 1'b1;
                    end
                end
                ST_CLEAR: begin
                    if (abort) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end else begin
                        cyc_cnt  <= '0;
                        ones_cnt <= '0;
                        state    <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (abort) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end else if (last_run) begin
                        result <= ones_total;
                        state  <= ST_DONE;
                        busy   <= 1'b0;
                        done   <= 1'b1;
                    end else begin
                        cyc_cnt  <= cyc_cnt + RESULT_WIDTH'(1);
                        ones_cnt <= ones_total;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
